// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter / next-PC selection block.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_RET    = 2'd3
  } pc_sel_e;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_PC_INC    = 2;
  localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack kept as a circular buffer: a push when full overwrites the
// oldest entry, and a pop when empty only raises the sticky underflow flag.
module ras_stack #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_data,
  output logic [ADDR_W-1:0]              top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  top_ptr_q, top_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [PTR_W-1:0]  push_ptr_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_W'(RAS_DEPTH - 1)) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == '0) begin
      r = PTR_W'(RAS_DEPTH - 1);
    end else begin
      r = p - PTR_W'(1);
    end
    return r;
  endfunction

  assign push_ptr_s = ptr_inc(top_ptr_q);

  // Next stack state; pop takes precedence should both requests arrive together.
  always_comb begin
    mem_d       = mem_q;
    top_ptr_d   = top_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (pop) begin
      if (count_q != '0) begin
        top_ptr_d = ptr_dec(top_ptr_q);
        count_d   = count_q - CNT_W'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end else if (push) begin
      // When full, the slot after top is the oldest entry, so it is overwritten.
      top_ptr_d          = push_ptr_s;
      mem_d[push_ptr_s]  = push_data;
      if (count_q == CNT_W'(RAS_DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      top_ptr_d = top_ptr_q;
    end
  end

  // Pointer, occupancy and sticky flags; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr_q   <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      top_ptr_q   <= top_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage; contents are meaningless after reset, so it is left unreset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top       = mem_q[top_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/next_pc_unit.sv
// Architectural PC register with a prioritised next-PC selector
// (return > jump/call > branch > sequential), stall hold and return-address stack.
module next_pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                PC_INC    = DEF_PC_INC,
  parameter int                RAS_DEPTH = DEF_RAS_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [ADDR_W-1:0]              branch_target,
  input  logic                           jump_sel,
  input  logic [ADDR_W-1:0]              jump_target,
  input  logic                           call,
  input  logic                           ret,
  output logic [ADDR_W-1:0]              pc,
  output logic [ADDR_W-1:0]              pc_next,
  output logic [ADDR_W-1:0]              link_addr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] seq_pc_s;
  logic [ADDR_W-1:0] ras_top_s;
  pc_sel_e           sel_s;
  logic              ras_push_s;
  logic              ras_pop_s;
  logic              ras_empty_s;

  // Wraps modulo 2^ADDR_W; the carry is intentionally discarded.
  assign seq_pc_s    = pc_q + ADDR_W'(PC_INC);
  assign ras_empty_s = (ras_count == '0);

  // Priority encoder over the redirect requests.
  always_comb begin
    sel_s = SEL_SEQ;
    if (ret) begin
      sel_s = SEL_RET;
    end else if (call || jump_sel) begin
      sel_s = SEL_JUMP;
    end else if (branch_taken) begin
      sel_s = SEL_BRANCH;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-PC mux; a return on an empty stack falls through to the sequential PC.
  always_comb begin
    pc_d = seq_pc_s;
    if (stall) begin
      pc_d = pc_q;
    end else begin
      case (sel_s)
        SEL_RET:    pc_d = ras_empty_s ? seq_pc_s : ras_top_s;
        SEL_JUMP:   pc_d = jump_target;
        SEL_BRANCH: pc_d = branch_target;
        SEL_SEQ:    pc_d = seq_pc_s;
        default:    pc_d = seq_pc_s;
      endcase
    end
  end

  assign ras_pop_s  = !stall && ret;
  assign ras_push_s = !stall && !ret && call;

  // Architectural PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (seq_pc_s),
    .top       (ras_top_s),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign link_addr = seq_pc_s;

endmodule
